// File: rtl/spi_pkg.sv
// spi_pkg: shared state type, mode decoding and counter sizing for the SPI initiator
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
  localparam int MaxBitWidth = 32;
  localparam int EdgeW = $clog2(2 * MaxBitWidth + 1);
  function automatic logic cpol(input int mode);
    return mode[1];
  endfunction
  function automatic logic cpha(input int mode);
    return mode[0];
  endfunction
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: parallel handshake plus SPI pins between the initiator and its user
interface spi_master_if #(parameter int BitWidth = 8);
  logic start, busy, dOutVALID, sclk, mosi, miso, ss;
  logic [BitWidth-1:0] dIN, dOUT;
  modport master(input start, dIN, miso, output busy, dOUT, dOutVALID, sclk, mosi, ss);
  modport slave(output start, dIN, miso, input busy, dOUT, dOutVALID, sclk, mosi, ss);
endinterface

// File: rtl/spi_clkgen.sv
// spi_clkgen: phase divider and sclk edge counter; flags sample/shift edges for the shifters
module spi_clkgen import spi_pkg::*; #(
  parameter int BitWidth = 8,
  parameter int Mode = 1,
  parameter int ClkDiv = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clk_en,
  input  state_t state,
  output logic   sclk,
  output logic   lead_pulse,
  output logic   trail_pulse,
  output logic   done,
  output logic   sample,
  output logic   shift
);
  localparam int DivW = ClkDiv > 1 ? $clog2(ClkDiv) : 1;
  logic [DivW-1:0] div;
  logic [EdgeW-1:0] edges;
  logic wrap, toggle;
  assign wrap = state != IDLE && div == DivW'(ClkDiv - 1);
  assign toggle = wrap && state == XFER;
  assign lead_pulse = wrap && state == LEAD;
  assign trail_pulse = wrap && state == TRAIL;
  assign done = toggle && edges == EdgeW'(2 * BitWidth - 1);
  // edges holds toggles already made, so the upcoming toggle is number edges+1
  assign sample = toggle && edges[0] == cpha(Mode);
  assign shift = toggle && edges[0] != cpha(Mode) && edges != '0 && !done;
  always_ff @(posedge clk)
    if (rst) begin
      div <= '0;
      edges <= '0;
      sclk <= cpol(Mode);
    end else if (clk_en) begin
      div <= (state == IDLE || wrap) ? '0 : div + 1'b1;
      edges <= state == IDLE ? '0 : edges + EdgeW'(toggle);
      sclk <= state == IDLE ? cpol(Mode) : sclk ^ toggle;
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: SPI initiator FSM and shift registers, MSB first, single clock domain
module spi_master import spi_pkg::*; #(
  parameter int BitWidth = 8,
  parameter int Mode = 1,
  parameter int ClkDiv = 4
) (
  input logic clk,
  input logic rst,
  input logic clk_en,
  spi_master_if.master bus
);
  state_t state;
  logic [BitWidth-2:0] tx;
  logic [BitWidth-1:0] rx;
  logic lead_pulse, trail_pulse, done, sample, shift;
  spi_clkgen #(.BitWidth(BitWidth), .Mode(Mode), .ClkDiv(ClkDiv)) u_clkgen (
    .clk(clk), .rst(rst), .clk_en(clk_en), .state(state), .sclk(bus.sclk),
    .lead_pulse(lead_pulse), .trail_pulse(trail_pulse), .done(done),
    .sample(sample), .shift(shift)
  );
  // the word MSB goes straight to mosi, so tx only keeps the bits still to send
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= '0;
      rx <= '0;
      bus.ss <= 1'b1;
      bus.mosi <= 1'b0;
      bus.busy <= 1'b0;
      bus.dOUT <= '0;
      bus.dOutVALID <= 1'b0;
    end else begin
      bus.dOutVALID <= 1'b0;
      if (clk_en)
        case (state)
          IDLE: if (bus.start) begin
            tx <= bus.dIN[BitWidth-2:0];
            bus.mosi <= bus.dIN[BitWidth-1];
            bus.ss <= 1'b0;
            bus.busy <= 1'b1;
            state <= LEAD;
          end
          LEAD: if (lead_pulse) state <= XFER;
          XFER: begin
            if (sample) rx <= {rx[BitWidth-2:0], bus.miso};
            if (shift) begin
              tx <= tx << 1;
              bus.mosi <= tx[BitWidth-2];
            end
            if (done) state <= TRAIL;
          end
          TRAIL: if (trail_pulse) begin
            bus.ss <= 1'b1;
            bus.mosi <= 1'b0;
            bus.busy <= 1'b0;
            bus.dOUT <= rx;
            bus.dOutVALID <= 1'b1;
            state <= IDLE;
          end
        endcase
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of all four SPI modes with loopback and a behavioural slave
module tb_spi_master;
  localparam int BW = 8;
  localparam int CD = 2;
  logic clk = 0, rst = 1, clk_en = 1, start = 0;
  logic [7:0] din = 0, stx = 0;
  bit loop = 1, div3 = 0;
  int ph = 0;
  logic [3:0] sclk_w, ss_w, mosi_w, busy_w, dv_w, smiso;
  logic [3:0] sclk_p = '0, ss_p = '0, mosi_p = '0, busy_p = '0, dv_p = '0;
  logic [7:0] dout_w [4];
  logic [7:0] srx [4];
  logic [7:0] ssh [4];
  int tog[4], mosi_bad[4], idle_bad[4], dv_wide[4], dvc[4], frames[4], gap[4], hi_cnt[4];
  int acc_en[4], acc_clk[4], lat[4], lat_clk[4];
  int en_total = 0, clk_total = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    clk_en = div3 ? (ph == 2) : 1'b1;
    ph = (ph + 1) % 3;
  end

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    spi_master_if #(.BitWidth(BW)) bus ();
    assign bus.start = start;
    assign bus.dIN = din;
    assign bus.miso = loop ? bus.mosi : smiso[g];
    assign sclk_w[g] = bus.sclk;
    assign ss_w[g] = bus.ss;
    assign mosi_w[g] = bus.mosi;
    assign busy_w[g] = bus.busy;
    assign dv_w[g] = bus.dOutVALID;
    assign dout_w[g] = bus.dOUT;
    spi_master #(.BitWidth(BW), .Mode(g), .ClkDiv(CD)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
    );
  end

  // bus monitor and behavioural slave, evaluated just after every rising edge
  always @(posedge clk) begin
    #1;
    clk_total++;
    if (clk_en) en_total++;
    for (int i = 0; i < 4; i++) begin
      if (ss_p[i] === 1'b1 && ss_w[i] === 1'b0) begin
        frames[i]++;
        gap[i] = hi_cnt[i];
        tog[i] = 0;
        srx[i] = '0;
        ssh[i] = stx;
      end
      if (ss_w[i] === 1'b1) begin
        if (clk_en) hi_cnt[i]++;
        if (sclk_w[i] !== i[1]) idle_bad[i]++;
      end else hi_cnt[i] = 0;
      if (ss_w[i] === 1'b0 && sclk_w[i] !== sclk_p[i]) begin
        tog[i]++;
        if ((tog[i] % 2 == 1) == (i[0] == 1'b0)) begin
          if (mosi_w[i] !== mosi_p[i]) mosi_bad[i]++;
          srx[i] = {srx[i][6:0], mosi_w[i]};
        end else if (tog[i] > 1 && tog[i] < 2 * BW) ssh[i] = ssh[i] << 1;
      end
      smiso[i] = ssh[i][7];
      if (busy_p[i] === 1'b0 && busy_w[i] === 1'b1) begin
        acc_en[i] = en_total;
        acc_clk[i] = clk_total;
      end
      if (dv_w[i] === 1'b1) begin
        if (dv_p[i] === 1'b1) dv_wide[i]++;
        else begin
          dvc[i]++;
          lat[i] = en_total - acc_en[i];
          lat_clk[i] = clk_total - acc_clk[i];
        end
      end
    end
    sclk_p = sclk_w;
    ss_p = ss_w;
    mosi_p = mosi_w;
    busy_p = busy_w;
    dv_p = dv_w;
  end

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic kick(input logic [7:0] d, output bit ok);
    din = d;
    start = 1;
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = busy_w[0] === 1'b1;
    end
    start = 0;
  endtask

  task automatic wait_dv(input int n, output bit ok);
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      ok = dvc[0] >= n;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] got, want;
      got = {ss_w[i], sclk_w[i], mosi_w[i], busy_w[i], dv_w[i]};
      want = {1'b1, i[1], 3'b000};
      if (got !== want) begin bad++; $display("FAIL reset_pins m%0d: got %b want %b", i, got, want); end
      total++;
      if (dout_w[i] !== 8'h00) begin bad++; $display("FAIL reset_dout m%0d: got %h want 00", i, dout_w[i]); end
      total++;
    end
    rst = 0;
  endtask

  task automatic test_loopback();
    bit ok;
    int d0 = dvc[0];
    loop = 1;
    kick(8'hA5, ok);
    if (!ok) begin bad++; $display("FAIL lb_accept: got busy=%b want 1", busy_w[0]); end
    total++;
    wait_dv(d0 + 1, ok);
    if (!ok) begin bad++; $display("FAIL lb_timeout: got dv count %0d want %0d", dvc[0], d0 + 1); end
    total++;
    if (dout_w[0] !== 8'hA5) begin bad++; $display("FAIL lb_dout: got %h want a5", dout_w[0]); end
    total++;
    if (lat[0] !== 36) begin bad++; $display("FAIL lb_latency: got %0d want 36", lat[0]); end
    total++;
    if (tog[0] !== 16) begin bad++; $display("FAIL lb_toggles: got %0d want 16", tog[0]); end
    total++;
    repeat (2) @(negedge clk);
    if (sclk_w[0] !== 1'b0 || ss_w[0] !== 1'b1) begin bad++; $display("FAIL lb_idle: got sclk=%b ss=%b want 0 1", sclk_w[0], ss_w[0]); end
    total++;
  endtask

  task automatic test_modes();
    bit ok;
    int d0 = dvc[0];
    loop = 0;
    stx = 8'h3C;
    kick(8'h96, ok);
    wait_dv(d0 + 1, ok);
    if (!ok) begin bad++; $display("FAIL modes_timeout: got dv count %0d want %0d", dvc[0], d0 + 1); end
    total++;
    for (int i = 0; i < 4; i++) begin
      if (dout_w[i] !== 8'h3C) begin bad++; $display("FAIL modes_dout m%0d: got %h want 3c", i, dout_w[i]); end
      total++;
      if (srx[i] !== 8'h96) begin bad++; $display("FAIL modes_slave_rx m%0d: got %h want 96", i, srx[i]); end
      total++;
      if (lat[i] !== 36) begin bad++; $display("FAIL modes_latency m%0d: got %0d want 36", i, lat[i]); end
      total++;
      if (sclk_w[i] !== i[1]) begin bad++; $display("FAIL modes_sclk_idle m%0d: got %b want %b", i, sclk_w[i], i[1]); end
      total++;
    end
    loop = 1;
  endtask

  task automatic test_clk_en();
    bit ok;
    int d0 = dvc[0];
    div3 = 1;
    repeat (4) @(negedge clk);
    kick(8'hC3, ok);
    wait_dv(d0 + 1, ok);
    if (!ok) begin bad++; $display("FAIL en_timeout: got dv count %0d want %0d", dvc[0], d0 + 1); end
    total++;
    if (dout_w[1] !== 8'hC3) begin bad++; $display("FAIL en_dout: got %h want c3", dout_w[1]); end
    total++;
    if (lat[1] !== 36) begin bad++; $display("FAIL en_latency: got %0d want 36", lat[1]); end
    total++;
    if (lat_clk[1] !== 108) begin bad++; $display("FAIL en_latency_clk: got %0d want 108", lat_clk[1]); end
    total++;
    if (tog[1] !== 16) begin bad++; $display("FAIL en_toggles: got %0d want 16", tog[1]); end
    total++;
    repeat (3) @(negedge clk);
    if (dv_wide[1] !== 0) begin bad++; $display("FAIL en_dv_width: got %0d wide pulses want 0", dv_wide[1]); end
    total++;
    div3 = 0;
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int d0 = dvc[0];
    int f0 = frames[0];
    kick(8'h3C, ok);
    repeat (12) @(negedge clk);
    din = 8'hFF;
    start = 1;
    repeat (6) @(negedge clk);
    start = 0;
    wait_dv(d0 + 1, ok);
    if (!ok) begin bad++; $display("FAIL busy_timeout: got dv count %0d want %0d", dvc[0], d0 + 1); end
    total++;
    if (dout_w[0] !== 8'h3C) begin bad++; $display("FAIL busy_dout: got %h want 3c", dout_w[0]); end
    total++;
    repeat (10) @(negedge clk);
    if (frames[0] - f0 !== 1) begin bad++; $display("FAIL busy_frames: got %0d want 1", frames[0] - f0); end
    total++;
    if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL busy_not_queued: got %b want 0", busy_w[0]); end
    total++;
  endtask

  task automatic test_reset_abort();
    bit ok;
    int d0;
    do_reset();
    d0 = dvc[0];
    kick(8'h77, ok);
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = tog[0] == 5;
    end
    if (!ok) begin bad++; $display("FAIL abort_reach: got toggles %0d want 5", tog[0]); end
    total++;
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] got, want;
      got = {ss_w[i], sclk_w[i], busy_w[i], dv_w[i]};
      want = {1'b1, i[1], 2'b00};
      if (got !== want) begin bad++; $display("FAIL abort_pins m%0d: got %b want %b", i, got, want); end
      total++;
    end
    if (dout_w[0] !== 8'h00) begin bad++; $display("FAIL abort_dout: got %h want 00", dout_w[0]); end
    total++;
    rst = 0;
    repeat (4) @(negedge clk);
    if (dvc[0] !== d0) begin bad++; $display("FAIL abort_no_valid: got %0d want %0d", dvc[0], d0); end
    total++;
    kick(8'h5A, ok);
    wait_dv(d0 + 1, ok);
    if (dout_w[0] !== 8'h5A) begin bad++; $display("FAIL abort_restart: got %h want 5a", dout_w[0]); end
    total++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0 = dvc[0];
    int f0 = frames[0];
    din = 8'h01;
    start = 1;
    wait_dv(d0 + 1, ok);
    if (dout_w[0] !== 8'h01) begin bad++; $display("FAIL b2b_first: got %h want 01", dout_w[0]); end
    total++;
    din = 8'h80;
    @(negedge clk);
    start = 0;
    wait_dv(d0 + 2, ok);
    if (!ok) begin bad++; $display("FAIL b2b_timeout: got dv count %0d want %0d", dvc[0], d0 + 2); end
    total++;
    if (dout_w[0] !== 8'h80) begin bad++; $display("FAIL b2b_second: got %h want 80", dout_w[0]); end
    total++;
    if (gap[0] !== 1) begin bad++; $display("FAIL b2b_ss_gap: got %0d want 1", gap[0]); end
    total++;
    if (frames[0] - f0 !== 2) begin bad++; $display("FAIL b2b_frames: got %0d want 2", frames[0] - f0); end
    total++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_modes();
    test_clk_en();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mosi_bad[i] !== 0 || idle_bad[i] !== 0) begin
        bad++;
        $display("FAIL bus_rules m%0d: got mosi_changes=%0d idle_errors=%0d want 0 0", i, mosi_bad[i], idle_bad[i]);
      end
      total++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI bus initiator. Generates sclk and ss, shifts a parallel word out on mosi, and shifts the returned word in from miso, MSB first.
- Pairs with the existing SPI slave so our designs can drive off-chip SPI peripherals, and our own slave for loopback tests.
- Runs entirely in the system clock domain. sclk is derived from clk and clk_en; no second clock.

Parameters:
- BitWidth, 8, word length in bits; legal range 2..32.
- Mode, 1, SPI mode 0..3. CPOL = Mode[1], CPHA = Mode[0] (standard numbering).
- ClkDiv, 4, number of enabled clk cycles per sclk half-period; legal range >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  clock enable. When low, all state, counters and outputs hold.
- start  in  1  transfer request; sampled only when clk_en=1 and busy=0.
- dIN  in  BitWidth  transmit word; captured on the cycle start is accepted.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- dOUT  out  BitWidth  received word; holds its value until the next completed transfer.
- dOutVALID  out  1  one-clk pulse when dOUT updates.
- sclk  out  1  SPI clock; idles at CPOL.
- mosi  out  1  initiator data out.
- miso  in  1  responder data in.
- ss  out  1  active-low select; idles high.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of clk_en):
  - state=IDLE, ss=1, sclk=CPOL, mosi=0, busy=0, dOUT=0, dOutVALID=0, all counters 0.
  - Reset mid-transfer aborts the transfer: ss deasserts and sclk returns to CPOL on that edge, with no dOutVALID.
- All registers are updated only on clk edges with clk_en=1, except dOutVALID, which clears on the next clk edge regardless of clk_en.
- FSM states: IDLE, LEAD, XFER, TRAIL. A divider counter counts enabled cycles from 0 to ClkDiv-1; each phase advances when it wraps.
- IDLE:
  - On start, latch dIN into the tx shift register, drive ss=0 and mosi=dIN[MSB], clear counters, go to LEAD.
  - start while busy=1 is ignored; it is not queued.
- LEAD:
  - Lasts ClkDiv enabled cycles (ss-to-first-edge setup), then go to XFER.
- XFER:
  - sclk toggles on every divider wrap, 2*BitWidth toggles total, tracked by an edge counter.
  - Sample edge: leading edge (odd toggles) when CPHA=0; trailing edge (even toggles) when CPHA=1. miso is shifted into the rx register on each sample edge.
  - The tx register shifts left, and mosi takes the new MSB, on the toggle immediately following each sample. There is no shift after the BitWidth-th sample.
  - After the 2*BitWidth-th toggle, sclk is back at CPOL; go to TRAIL.
- TRAIL:
  - Lasts ClkDiv enabled cycles. On exit: ss=1, dOUT=rx register, dOutVALID=1 for one clk, mosi=0, go to IDLE.
  - start is accepted again on the first enabled cycle after returning to IDLE, so ss is high for at least one enabled cycle between words.
- Latency: from the start-accept edge to the dOutVALID edge is exactly ClkDiv*(2*BitWidth+2) enabled cycles.
- Boundary cases:
  - ClkDiv=1: sclk toggles every enabled cycle.
  - miso is sampled raw. Any synchronisation of miso is the integrator's responsibility.
  - dIN changing after the accept cycle has no effect on the current transfer.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, LEAD, XFER, TRAIL);
  - functions cpol(Mode) and cpha(Mode);
  - the localparam for edge-counter width, $clog2(2*BitWidth+1).
- One sub-module, spi_clkgen: the divider plus edge counter. It outputs sclk, lead_pulse, trail_pulse and a done flag. The top level holds the FSM and the shift registers.

Test Plan:
- Mode 0, ClkDiv=2, BitWidth=8, dIN=0xA5, miso tied to mosi → dOUT=0xA5 and dOutVALID after exactly 36 enabled cycles; sclk idles at 0; 16 toggles seen.
- Modes 0-3 each, with a behavioural slave model returning 0x3C and checking the received value equals 0x96 → all four modes report dOUT=0x3C and slave receives 0x96; sclk idle level equals CPOL; mosi stable on every sample edge.
- clk_en asserted every 3rd cycle, Mode 1 → the same waveforms stretched by 3x; latency is 36 enabled cycles; dOutVALID is a single clk wide.
- start pulsed again while busy, mid-XFER, with dIN=0xFF → ignored; dOUT still reflects the first word; one ss low period only.
- rst asserted at the 5th sclk toggle → the next edge gives ss=1, sclk=CPOL, busy=0, no dOutVALID, dOUT unchanged (0 after reset); a following start with 0x5A completes normally.
- Back-to-back: start held high permanently, with 0x01 then 0x80 → two transfers; ss high for at least one enabled cycle between them; dOUT sequence 0x01, 0x80 in loopback.
